fb_io_stream_in: RTL and testbench
==================================

FB_IO_STREAM_IN -- requirements
Module: fb_io_stream_in

Interface
REQ-001 Parameters SHALL be:
- size, default 32, data width in bits.
- depth, default 4, FIFO entries; power of two, at least 2.

REQ-002 Ports SHALL be:
- clk  in  1  fabric clock.
- reset  in  1  fabric reset.
- config_clk  in  1  configuration shift clock.
- config_reset  in  1  configuration clear; asynchronous, active-high.
- config_in  in  1  configuration serial input.
- config_out  out  1  configuration serial output.
- start  in  1  single-cycle run request.
- in_data  in  size  external stream data.
- in_valid  in  1  external data valid.
- in_ready  out  1  FIFO can accept a word.
- out0  out  size  data to fabric, registered.
- out_valid  out  1  out0 holds a new token this cycle.
- stall  out  1  issue slot reached with FIFO empty.
- done  out  1  configured token count emitted.

REQ-003 Reset SHALL be reset: asynchronous, active-high. The clock SHALL be clk.

Function
REQ-004 Configuration SHALL use a 13-bit register cfg.
- Each config_clk rising edge: cfg <= {config_in, cfg[12:1]}.
- config_out = cfg[0].
- config_reset clears cfg to 0 asynchronously.
- reset SHALL NOT affect cfg.

REQ-005 cfg fields SHALL be:
- cfg[0] enable.
- cfg[4:1] ii_m1; issue interval is ii_m1+1 cycles (1..16).
- cfg[12:5] count; 0 means unlimited.

REQ-006 FIFO behaviour:
- in_ready = !full, decoded from registered pointers.
- Push occurs when in_valid && in_ready.
- Pop occurs only on an issue (REQ-009).
- Push and pop in the same cycle SHALL keep occupancy unchanged.
- Pointers SHALL wrap modulo depth.
- A push while full is impossible, because in_ready is 0.

REQ-007 The FSM SHALL have states IDLE, RUN and DONE.
- IDLE -> RUN when start && enable. On this transition: emitted <= 0 and ivl <= 0.
- RUN -> DONE on the issue that makes emitted == count, when count != 0.
- DONE -> RUN when start && enable, with the same clears as IDLE -> RUN.
- Any state -> IDLE when enable == 0.
- start SHALL be ignored while in RUN.

REQ-008 Interval counter ivl:
- In RUN, when ivl != 0: ivl decrements by 1.
- In RUN, when ivl == 0: this is an issue slot.

REQ-009 Issue slot with FIFO non-empty:
- Pop the head entry.
- out0 <= head.
- out_valid <= 1 for exactly one cycle.
- ivl <= ii_m1.
- emitted <= emitted + 1, an 8-bit counter that wraps when count == 0.

REQ-010 Issue slot with FIFO empty:
- stall <= 1.
- ivl stays 0.
- out0 holds its value.
- No pop.
- The issue occurs on the first cycle a word is present.

REQ-011 With ii_m1 == 0 and a FIFO that never runs empty, out_valid SHALL be 1 every cycle in RUN.

REQ-012 Data latency: a word pushed at edge N, into an empty FIFO, in RUN with ivl == 0, SHALL appear on out0 with out_valid at edge N+1.

REQ-013 Hold behaviour:
- out0 SHALL hold its last issued value in every non-issue cycle.
- out_valid and stall SHALL be 0 outside RUN.
- done = (state == DONE).

REQ-014 The FIFO SHALL keep accepting pushes in IDLE and DONE, so data may be preloaded before start.

Reset
REQ-015 While reset is asserted:
- state = IDLE.
- FIFO empty, pointers at 0.
- ivl = 0, emitted = 0.
- out0 = 0, out_valid = 0, stall = 0, done = 0.
- in_ready = 1.

REQ-016 If reset is asserted mid-RUN, buffered data SHALL be discarded.

REQ-017 After reset deasserts, the block SHALL stay in IDLE until the next start.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Preload, interval 1: cfg enable=1, ii_m1=0, count=3. Push 0xA, 0xB, 0xC, then start. out_valid is high for 3 consecutive cycles carrying 0xA, 0xB, 0xC. done rises on the cycle after the third issue.
- Interval 3: ii_m1=2, count=2, FIFO preloaded. Issues occur 3 cycles apart. out0 holds 0xA between the two issues.
- Underflow: ii_m1=0, count=0, FIFO empty, then start. stall=1 each cycle. Push 0x55. out0=0x55 and out_valid=1 on the next edge, and stall drops.
- Full: push depth words with no start. in_ready=0. A further in_valid is not accepted. After start, the first issue raises in_ready on the following cycle.
- Reset mid-RUN: 2 words buffered, assert reset. All outputs are 0 and in_ready=1. cfg readback through config_out is unchanged.
- Config chain: shift 13 bits through the chain, then 13 more. config_out reproduces the first 13 bits in order. config_reset clears cfg.

Source files
------------

// File: rtl/fb_io_stream_in.sv
// Stream input port: buffers external words in a small FIFO and issues them
// to the fabric at a configurable interval, with a serially loaded config.
module fb_io_stream_in #(
  parameter int size  = 32,
  parameter int depth = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            config_clk,
  input  logic            config_reset,
  input  logic            config_in,
  output logic            config_out,
  input  logic            start,
  input  logic [size-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [size-1:0] out0,
  output logic            out_valid,
  output logic            stall,
  output logic            done
);
  localparam int aw = $clog2(depth);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  logic [12:0]     cfg;
  logic            enable;
  logic [3:0]      ii_m1;
  logic [7:0]      count;

  logic [size-1:0] mem [depth];
  logic [aw:0]     wr_ptr;
  logic [aw:0]     rd_ptr;
  logic            empty;
  logic            full;
  logic            push;
  logic            issue;
  logic [size-1:0] head;

  state_t          state;
  logic [3:0]      ivl;
  logic [7:0]      emitted;
  logic [7:0]      emitted_next;

  // Config shift chain lives in its own clock domain and ignores fabric reset.
  always_ff @(posedge config_clk or posedge config_reset) begin
    if (config_reset) cfg <= '0;
    else              cfg <= {config_in, cfg[12:1]};
  end

  assign config_out = cfg[0];
  assign enable     = cfg[0];
  assign ii_m1      = cfg[4:1];
  assign count      = cfg[12:5];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign head     = mem[rd_ptr[aw-1:0]];

  assign issue        = (state == RUN) && enable && (ivl == 4'd0) && !empty;
  assign emitted_next = emitted + 8'd1;
  assign done         = (state == DONE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[aw-1:0]] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ivl       <= 4'd0;
      emitted   <= 8'd0;
      out0      <= '0;
      out_valid <= 1'b0;
      stall     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      stall     <= 1'b0;
      if (!enable) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              state   <= RUN;
              emitted <= 8'd0;
              ivl     <= 4'd0;
            end
          end
          RUN: begin
            if (ivl != 4'd0) begin
              ivl <= ivl - 4'd1;
            end else if (!empty) begin
              out0      <= head;
              out_valid <= 1'b1;
              ivl       <= ii_m1;
              emitted   <= emitted_next;
              if (count != 8'd0 && emitted_next == count) state <= DONE;
            end else begin
              stall <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fb_io_stream_in.sv
// Directed bench for fb_io_stream_in: a scoreboard queue holds the words the
// fabric should see, and a negedge monitor checks every out_valid beat.
module tb_fb_io_stream_in;
  localparam int size  = 32;
  localparam int depth = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            config_clk = 1'b0;
  logic            config_reset = 1'b1;
  logic            config_in = 1'b0;
  logic            config_out;
  logic            start = 1'b0;
  logic [size-1:0] in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [size-1:0] out0;
  logic            out_valid;
  logic            stall;
  logic            done;

  int total = 0;
  int bad   = 0;
  logic [size-1:0] sb [$];

  fb_io_stream_in #(.size(size), .depth(depth)) dut (
    .clk(clk), .reset(reset),
    .config_clk(config_clk), .config_reset(config_reset),
    .config_in(config_in), .config_out(config_out),
    .start(start), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out0(out0), .out_valid(out_valid), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  // Every issued word must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (out_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL sb_unexpected: got out0=%h, expected no output", out0);
      end else begin
        logic [size-1:0] exp;
        exp = sb.pop_front();
        if (out0 !== exp) begin
          bad++;
          $display("[TB] FAIL sb_data: got out0=%h, expected %h", out0, exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cfg_shift(input logic b, output logic q);
    q = config_out;
    config_in = b;
    #3 config_clk = 1'b1;
    #3 config_clk = 1'b0;
  endtask

  task automatic program_cfg(input logic en, input logic [3:0] ii, input logic [7:0] cnt);
    logic [12:0] v;
    logic q;
    v = {cnt, ii, en};
    for (int i = 0; i < 13; i++) cfg_shift(v[i], q);
    tick();
  endtask

  // Rotates cfg once around so the register ends up unchanged.
  task automatic read_cfg(output logic [12:0] v);
    logic q;
    for (int i = 0; i < 13; i++) begin
      q = config_out;
      v[i] = q;
      cfg_shift(q, q);
    end
  endtask

  task automatic apply_stimulus(input logic [size-1:0] w, input logic expect_out);
    in_valid = 1'b1;
    in_data  = w;
    if (expect_out) sb.push_back(w);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [12:0] rd;
    logic [12:0] pat;
    logic [12:0] cap;
    logic q;

    tick();
    check_output("rst_out0", out0, 32'h0);
    check_output("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check_output("rst_stall", {31'b0, stall}, 32'h0);
    check_output("rst_done", {31'b0, done}, 32'h0);
    check_output("rst_in_ready", {31'b0, in_ready}, 32'h1);
    config_reset = 1'b0;
    reset = 1'b0;
    tick();

    // Preload three words, interval 1, count 3.
    program_cfg(1'b1, 4'd0, 8'd3);
    apply_stimulus(32'hA, 1'b1);
    apply_stimulus(32'hB, 1'b1);
    apply_stimulus(32'hC, 1'b1);
    pulse_start();
    check_output("p1_idle_gap", {31'b0, out_valid}, 32'h0);
    tick();
    check_output("p1_beat0", {out_valid, out0[30:0]}, {1'b1, 31'hA});
    tick();
    check_output("p1_beat1", {out_valid, out0[30:0]}, {1'b1, 31'hB});
    tick();
    check_output("p1_beat2", {out_valid, out0[30:0]}, {1'b1, 31'hC});
    check_output("p1_done", {31'b0, done}, 32'h1);
    tick();
    check_output("p1_after", {30'b0, out_valid, done}, 32'h1);

    // Interval 3, count 2.
    program_cfg(1'b1, 4'd2, 8'd2);
    apply_stimulus(32'hA, 1'b1);
    apply_stimulus(32'hB, 1'b1);
    pulse_start();
    tick();
    check_output("i3_first", {out_valid, out0[30:0]}, {1'b1, 31'hA});
    tick();
    check_output("i3_hold1", {out_valid, out0[30:0]}, {1'b0, 31'hA});
    tick();
    check_output("i3_hold2", {out_valid, out0[30:0]}, {1'b0, 31'hA});
    tick();
    check_output("i3_second", {out_valid, out0[30:0]}, {1'b1, 31'hB});
    check_output("i3_done", {31'b0, done}, 32'h1);

    // Underflow with unlimited count.
    program_cfg(1'b1, 4'd0, 8'd0);
    pulse_start();
    tick();
    check_output("uf_stall0", {31'b0, stall}, 32'h1);
    tick();
    check_output("uf_stall1", {31'b0, stall}, 32'h1);
    apply_stimulus(32'h55, 1'b1);
    check_output("uf_pending", {30'b0, stall, out_valid}, 32'h2);
    tick();
    check_output("uf_issue", {stall, out_valid, out0[29:0]}, {2'b01, 30'h55});
    tick();
    check_output("uf_restall", {31'b0, stall}, 32'h1);

    // Full FIFO: preload depth words without start.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    program_cfg(1'b1, 4'd0, 8'd4);
    check_output("full_idle", {29'b0, stall, out_valid, done}, 32'h0);
    for (int i = 0; i < depth; i++) apply_stimulus(32'hD0 + i, 1'b1);
    check_output("full_ready", {31'b0, in_ready}, 32'h0);
    apply_stimulus(32'hBAD, 1'b0);
    check_output("full_reject", {31'b0, in_ready}, 32'h0);
    pulse_start();
    check_output("full_start", {31'b0, in_ready}, 32'h0);
    tick();
    check_output("full_first", {in_ready, out_valid, out0[29:0]}, {2'b11, 30'hD0});
    tick();
    tick();
    tick();
    check_output("full_done", {out_valid, done, out0[29:0]}, {2'b11, 30'hD3});

    // Reset in the middle of a run with two words buffered.
    program_cfg(1'b1, 4'd15, 8'd0);
    pulse_start();
    apply_stimulus(32'h71, 1'b1);
    apply_stimulus(32'h72, 1'b0);
    apply_stimulus(32'h73, 1'b0);
    check_output("mr_issued", out0, 32'h71);
    reset = 1'b1;
    #1;
    check_output("mr_out0", out0, 32'h0);
    check_output("mr_flags", {28'b0, out_valid, stall, done, in_ready}, 32'h1);
    tick();
    reset = 1'b0;
    tick();
    tick();
    check_output("mr_idle", {30'b0, stall, out_valid}, 32'h0);
    read_cfg(rd);
    check_output("mr_cfg", {19'b0, rd}, {19'b0, 8'd0, 4'd15, 1'b1});
    tick();
    pulse_start();
    tick();
    tick();
    check_output("mr_discard", {30'b0, stall, out_valid}, 32'h2);

    // Config chain readback and clear.
    pat = 13'h1674;
    for (int i = 0; i < 13; i++) cfg_shift(pat[i], q);
    for (int i = 0; i < 13; i++) begin
      cfg_shift(1'b0, q);
      cap[i] = q;
    end
    check_output("cc_readback", {19'b0, cap}, {19'b0, pat});
    for (int i = 0; i < 13; i++) cfg_shift(pat[i], q);
    check_output("cc_loaded", {31'b0, config_out}, {31'b0, pat[0]});
    config_reset = 1'b1;
    #2;
    check_output("cc_clear_out", {31'b0, config_out}, 32'h0);
    config_reset = 1'b0;
    read_cfg(rd);
    check_output("cc_clear_cfg", {19'b0, rd}, 32'h0);

    tick();
    tick();
    check_output("sb_drained", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
